// File: rtl/menu_state_controller.sv
// -----------------------------------------------------------------------------
// menu_state_controller
//
// Mode-selection controller fed by the debounced per-button press detectors.
// Left/right presses walk a 4-entry menu, the centre press commits the
// highlighted entry as the active mode, and a third centre press (or a
// simultaneous left+right press) returns to the menu. Every transition passes
// through a SETTLE window during which new_state is held high so that all
// detectors clear their press counts and latches.
//
// Parameters
//   SETTLE_CYCLES : cycles new_state stays high per transition (legal 1..255)
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   btnC_press   in   unlatched press level from the centre-button detector
//   btnL_press   in   unlatched press level from the left-button detector
//   btnR_press   in   unlatched press level from the right-button detector
//   btnC_count   in   2-bit centre press count from the centre detector
//   new_state    out  high while settling; clears every detector
//   selection    out  currently highlighted menu entry
//   mode         out  committed mode, meaningful while active = 1
//   active       out  high while in the ACTIVE state
//   mode_entered out  one-cycle pulse on the first ACTIVE cycle
// -----------------------------------------------------------------------------
module menu_state_controller #(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btnC_press,
   input  logic       btnL_press,
   input  logic       btnR_press,
   input  logic [1:0] btnC_count,
   output logic       new_state,
   output logic [1:0] selection,
   output logic [1:0] mode,
   output logic       active,
   output logic       mode_entered
);

   typedef enum logic [1:0] {
      ST_MENU   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_SETTLE = 2'd2
   } state_t;

   // Value loaded into the settle counter; the window ends when it reaches 0,
   // so loading SETTLE_CYCLES-1 yields exactly SETTLE_CYCLES high cycles.
   localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

   // State registers and their next-state values.
   state_t     state_q,  state_d;
   state_t     target_q, target_d;
   logic [7:0] settle_cnt_q, settle_cnt_d;
   logic [1:0] selection_q,  selection_d;
   logic [1:0] mode_q,       mode_d;

   // Registered outputs.
   logic new_state_q;
   logic active_q;
   logic mode_entered_q;

   // Previous press levels for rising-edge detection.
   logic prev_c_q;
   logic prev_l_q;
   logic prev_r_q;

   logic c_edge;
   logic l_edge;
   logic r_edge;

   // A press counts once, on its rising edge; a held button never repeats.
   assign c_edge = btnC_press & ~prev_c_q;
   assign l_edge = btnL_press & ~prev_l_q;
   assign r_edge = btnR_press & ~prev_r_q;

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      state_d      = state_q;
      target_d     = target_q;
      settle_cnt_d = settle_cnt_q;
      selection_d  = selection_q;
      mode_d       = mode_q;

      unique case (state_q)
         ST_MENU: begin
            // Centre wins over any left/right edge in the same cycle.
            if (c_edge) begin
               mode_d       = selection_q;
               target_d     = ST_ACTIVE;
               settle_cnt_d = SETTLE_LOAD;
               state_d      = ST_SETTLE;
            end else if (r_edge && !l_edge) begin
               selection_d = selection_q + 2'd1;   // wraps 3 -> 0
            end else if (l_edge && !r_edge) begin
               selection_d = selection_q - 2'd1;   // wraps 0 -> 3
            end
         end

         ST_ACTIVE: begin
            // The centre detector's count reaches 3 on the third press since
            // it was last cleared, i.e. since ACTIVE was entered.
            if ((btnC_count == 2'b11) || (l_edge && r_edge)) begin
               target_d     = ST_MENU;
               settle_cnt_d = SETTLE_LOAD;
               state_d      = ST_SETTLE;
            end
         end

         ST_SETTLE: begin
            // Press inputs are ignored here; only the counter matters.
            if (settle_cnt_q == 8'd0) begin
               state_d = target_q;
            end else begin
               settle_cnt_d = settle_cnt_q - 8'd1;
            end
         end

         default: begin
            // Unused encoding: recover through a full settle into the menu.
            target_d     = ST_MENU;
            settle_cnt_d = SETTLE_LOAD;
            state_d      = ST_SETTLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // Reset lands in SETTLE so the detectors are cleared before MENU.
         state_q        <= ST_SETTLE;
         target_q       <= ST_MENU;
         settle_cnt_q   <= SETTLE_LOAD;
         selection_q    <= 2'd0;
         mode_q         <= 2'd0;
         new_state_q    <= 1'b1;
         active_q       <= 1'b0;
         mode_entered_q <= 1'b0;
         prev_c_q       <= 1'b0;
         prev_l_q       <= 1'b0;
         prev_r_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         target_q       <= target_d;
         settle_cnt_q   <= settle_cnt_d;
         selection_q    <= selection_d;
         mode_q         <= mode_d;
         // Outputs are decoded from the next state so they line up with the
         // state register rather than lagging it by a cycle.
         new_state_q    <= (state_d == ST_SETTLE);
         active_q       <= (state_d == ST_ACTIVE);
         mode_entered_q <= (state_q == ST_SETTLE) && (state_d == ST_ACTIVE);
         // Prev registers track the inputs in every state, so a button held
         // across the end of SETTLE produces no edge afterwards.
         prev_c_q       <= btnC_press;
         prev_l_q       <= btnL_press;
         prev_r_q       <= btnR_press;
      end
   end

   assign new_state    = new_state_q;
   assign selection    = selection_q;
   assign mode         = mode_q;
   assign active       = active_q;
   assign mode_entered = mode_entered_q;

endmodule

// File: tb/tb_menu_state_controller.sv
// -----------------------------------------------------------------------------
// tb_menu_state_controller
//
// Self-checking bench for menu_state_controller. A driver applies directed and
// randomized press patterns one cycle at a time and pushes the reference
// model's expected outputs into a queue; a monitor on the falling clock edge
// pops each entry and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_menu_state_controller;

   localparam int SC = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       btnC_press;
   logic       btnL_press;
   logic       btnR_press;
   logic [1:0] btnC_count;
   logic       new_state;
   logic [1:0] selection;
   logic [1:0] mode;
   logic       active;
   logic       mode_entered;

   always #5 clk = ~clk;

   menu_state_controller #(
      .SETTLE_CYCLES(SC)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .btnC_press  (btnC_press),
      .btnL_press  (btnL_press),
      .btnR_press  (btnR_press),
      .btnC_count  (btnC_count),
      .new_state   (new_state),
      .selection   (selection),
      .mode        (mode),
      .active      (active),
      .mode_entered(mode_entered)
   );

   typedef struct packed {
      logic       ns;
      logic       act;
      logic [1:0] sel;
      logic [1:0] md;
      logic       me;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   // ---------------------------------------------------------------------------
   // Reference model: menu position as an integer modulo 4, a count of settle
   // clock edges still to run, and the side the settle window lands on.
   // ---------------------------------------------------------------------------
   int m_sel;
   int m_mode;
   int m_settle_left;
   bit m_active;
   bit m_goal_active;
   bit m_entered;
   bit m_pc, m_pl, m_pr;

   function automatic void model_reset();
      m_sel         = 0;
      m_mode        = 0;
      m_settle_left = SC;
      m_active      = 1'b0;
      m_goal_active = 1'b0;
      m_entered     = 1'b0;
      m_pc          = 1'b0;
      m_pl          = 1'b0;
      m_pr          = 1'b0;
   endfunction

   function automatic void model_step(bit c_in, bit l_in, bit r_in, logic [1:0] cnt_in);
      bit ce, le, re;
      ce = c_in & ~m_pc;
      le = l_in & ~m_pl;
      re = r_in & ~m_pr;
      m_entered = 1'b0;
      if (m_settle_left > 0) begin
         m_settle_left--;
         if (m_settle_left == 0) begin
            m_active  = m_goal_active;
            m_entered = m_goal_active;
         end
      end else if (!m_active) begin
         if (ce) begin
            m_mode        = m_sel;
            m_goal_active = 1'b1;
            m_settle_left = SC;
         end else if (re && !le) begin
            m_sel = (m_sel + 1) % 4;
         end else if (le && !re) begin
            m_sel = (m_sel + 3) % 4;
         end
      end else if (cnt_in == 2'b11 || (le && re)) begin
         m_active      = 1'b0;
         m_goal_active = 1'b0;
         m_settle_left = SC;
      end
      m_pc = c_in;
      m_pl = l_in;
      m_pr = r_in;
   endfunction

   function automatic exp_t model_out();
      exp_t o;
      o.ns  = (m_settle_left > 0);
      o.act = m_active;
      o.sel = 2'(m_sel);
      o.md  = 2'(m_mode);
      o.me  = m_entered;
      return o;
   endfunction

   task automatic check(string name, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Driver: called just after a rising edge. Inputs (and reset) change here;
   // the expected outputs for the coming falling edge are queued, then the
   // model advances on the next rising edge.
   // ---------------------------------------------------------------------------
   task automatic cycle(bit c_in, bit l_in, bit r_in, logic [1:0] cnt_in, bit rst_in);
      btnC_press = c_in;
      btnL_press = l_in;
      btnR_press = r_in;
      btnC_count = cnt_in;
      reset      = rst_in;
      if (rst_in) model_reset();
      exp_q.push_back(model_out());
      @(posedge clk);
      if (!rst_in) model_step(c_in, l_in, r_in, cnt_in);
      #1;
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
   endtask

   // ---------------------------------------------------------------------------
   // Monitor
   // ---------------------------------------------------------------------------
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         mon_e = exp_q.pop_front();
         check("new_state",    new_state,    mon_e.ns);
         check("active",       active,       mon_e.act);
         check("selection",    selection,    mon_e.sel);
         check("mode",         mode,         mon_e.md);
         check("mode_entered", mode_entered, mon_e.me);
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1, "watchdog expired");
   end

   // ---------------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------------
   initial begin
      bit         rc, rl, rr, rrst;
      logic [1:0] rcnt;

      reset      = 1'b1;
      btnC_press = 1'b0;
      btnL_press = 1'b0;
      btnR_press = 1'b0;
      btnC_count = 2'd0;
      model_reset();
      @(posedge clk);
      #1;

      // Reset release and the initial settle window.
      cycle(0, 0, 0, 2'd0, 1);
      cycle(0, 0, 0, 2'd0, 1);
      idle(6);

      // Menu navigation: five R pulses, two L pulses, then L+R together.
      for (int i = 0; i < 5; i++) begin
         cycle(0, 0, 1, 2'd0, 0);
         cycle(0, 0, 0, 2'd0, 0);
      end
      for (int i = 0; i < 2; i++) begin
         cycle(0, 1, 0, 2'd0, 0);
         cycle(0, 0, 0, 2'd0, 0);
      end
      cycle(0, 1, 1, 2'd0, 0);
      cycle(0, 0, 0, 2'd0, 0);

      // Move from 3 to 2, enter, then a lone L in ACTIVE.
      cycle(0, 1, 0, 2'd0, 0);
      cycle(0, 0, 0, 2'd0, 0);
      cycle(1, 0, 0, 2'd0, 0);
      idle(6);
      cycle(0, 1, 0, 2'd0, 0);
      idle(2);

      // Exit by centre count 1 -> 2 -> 3.
      cycle(0, 0, 0, 2'd1, 0);
      cycle(0, 0, 0, 2'd2, 0);
      cycle(0, 0, 0, 2'd3, 0);
      idle(6);

      // Re-enter, then exit with a same-cycle L+R.
      cycle(1, 0, 0, 2'd0, 0);
      idle(6);
      cycle(0, 1, 1, 2'd0, 0);
      idle(6);

      // C+R together in MENU: entry with selection unchanged.
      cycle(1, 0, 1, 2'd0, 0);
      idle(6);

      // R held from ACTIVE through the whole exit settle, released in MENU.
      cycle(0, 0, 1, 2'd0, 0);
      cycle(0, 0, 1, 2'd3, 0);
      for (int i = 0; i < 7; i++) cycle(0, 0, 1, 2'd0, 0);
      idle(3);

      // Reset on the second new_state cycle of a MENU -> ACTIVE transition.
      cycle(1, 0, 0, 2'd0, 0);
      cycle(0, 0, 0, 2'd0, 0);
      cycle(0, 0, 0, 2'd0, 1);
      cycle(0, 0, 0, 2'd0, 1);
      idle(8);

      // Randomized phase: press levels toggle at random, occasional counts
      // and occasional asynchronous resets.
      rc = 1'b0;
      rl = 1'b0;
      rr = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 5) == 0) rc = ~rc;
         if ($urandom_range(0, 3) == 0) rl = ~rl;
         if ($urandom_range(0, 3) == 0) rr = ~rr;
         rcnt = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
         rrst = ($urandom_range(0, 299) == 0);
         cycle(rc, rl, rr, rcnt, rrst);
      end
      idle(4);

      @(negedge clk);
      check("queue_drained", 8'(exp_q.size()), 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
